// File: rtl/conv_window_scan_ctrl.sv
// Load/scan sequencer for the 3-row windowed feature memory: raster-loads the image,
// then steps the 3x3 window centre over every interior position under engine backpressure.
module conv_window_scan_ctrl #(
   parameter int DW       = 8,
   parameter int IMG_SIZE = 5,
   parameter int MEM_ADDR = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [DW-1:0]       pix_in,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic [DW-1:0]       mem_data_in,
   output logic                mem_wr_en,
   output logic                mem_rd_en,
   output logic [MEM_ADDR-1:0] mem_in_add_row,
   output logic [MEM_ADDR-1:0] mem_in_add_col,
   output logic [MEM_ADDR-1:0] mem_a_add_row,
   output logic [MEM_ADDR-1:0] mem_a_add_col,
   output logic                win_valid,
   input  logic                win_ready,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

   localparam logic [MEM_ADDR-1:0] LP_ZERO    = '0;
   localparam logic [MEM_ADDR-1:0] LP_ONE     = MEM_ADDR'(1);
   localparam logic [MEM_ADDR-1:0] LP_WR_LAST = MEM_ADDR'(IMG_SIZE - 1);
   localparam logic [MEM_ADDR-1:0] LP_RD_LAST = MEM_ADDR'(IMG_SIZE - 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [MEM_ADDR-1:0] r_wr_row;
   logic [MEM_ADDR-1:0] r_wr_col;
   logic [MEM_ADDR-1:0] r_rd_row;
   logic [MEM_ADDR-1:0] r_rd_col;
   logic                w_pix_acc;
   logic                w_win_acc;
   logic                w_wr_last;
   logic                w_rd_last;

   // pix_ready/win_valid are already gated by abort, so an abort cycle never accepts
   assign w_pix_acc = pix_ready & pix_valid;
   assign w_win_acc = win_valid & win_ready;
   assign w_wr_last = (r_wr_row == LP_WR_LAST) && (r_wr_col == LP_WR_LAST);
   assign w_rd_last = (r_rd_row == LP_RD_LAST) && (r_rd_col == LP_RD_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (start)                  w_state_nxt = S_LOAD;
            S_LOAD: if (w_pix_acc && w_wr_last) w_state_nxt = S_SCAN;
            S_SCAN: if (w_win_acc && w_rd_last) w_state_nxt = S_DONE;
            S_DONE:                             w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      pix_ready      = 1'b0;
      mem_data_in    = '0;
      mem_wr_en      = 1'b0;
      mem_rd_en      = 1'b0;
      mem_in_add_row = LP_ZERO;
      mem_in_add_col = LP_ZERO;
      mem_a_add_row  = LP_ZERO;
      mem_a_add_col  = LP_ZERO;
      win_valid      = 1'b0;
      done           = 1'b0;
      busy           = (r_state != S_IDLE);
      case (r_state)
         S_LOAD: begin
            pix_ready      = !abort;
            mem_wr_en      = pix_valid && !abort;
            mem_data_in    = pix_in;
            mem_in_add_row = r_wr_row;
            mem_in_add_col = r_wr_col;
         end
         S_SCAN: begin
            mem_rd_en     = !abort;
            win_valid     = !abort;
            mem_a_add_row = r_rd_row;
            mem_a_add_col = r_rd_col;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Counters sit at zero outside their own phase, so every pass restarts cleanly
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_row <= LP_ZERO;
         r_wr_col <= LP_ZERO;
         r_rd_row <= LP_ZERO;
         r_rd_col <= LP_ZERO;
      end else begin
         if (r_state == S_LOAD) begin
            if (w_pix_acc) begin
               if (w_wr_last) begin
                  r_wr_row <= LP_ZERO;
                  r_wr_col <= LP_ZERO;
               end else if (r_wr_col == LP_WR_LAST) begin
                  r_wr_col <= LP_ZERO;
                  r_wr_row <= r_wr_row + LP_ONE;
               end else begin
                  r_wr_col <= r_wr_col + LP_ONE;
               end
            end
         end else begin
            r_wr_row <= LP_ZERO;
            r_wr_col <= LP_ZERO;
         end

         if (r_state == S_LOAD && w_pix_acc && w_wr_last) begin
            r_rd_row <= LP_ONE;
            r_rd_col <= LP_ONE;
         end else if (r_state == S_SCAN) begin
            if (w_win_acc) begin
               if (w_rd_last) begin
                  r_rd_row <= LP_ZERO;
                  r_rd_col <= LP_ZERO;
               end else if (r_rd_col == LP_RD_LAST) begin
                  r_rd_col <= LP_ONE;
                  r_rd_row <= r_rd_row + LP_ONE;
               end else begin
                  r_rd_col <= r_rd_col + LP_ONE;
               end
            end
         end else begin
            r_rd_row <= LP_ZERO;
            r_rd_col <= LP_ZERO;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_scan_ctrl.sv
// Bench for conv_window_scan_ctrl: control vector table plus full load/scan passes
// with write and window scoreboards.
module tb_conv_window_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic [7:0] mem_data_in;
   logic       mem_wr_en;
   logic       mem_rd_en;
   logic [2:0] mem_in_add_row;
   logic [2:0] mem_in_add_col;
   logic [2:0] mem_a_add_row;
   logic [2:0] mem_a_add_col;
   logic       win_valid;
   logic       win_ready = 1'b0;
   logic       busy;
   logic       done;

   conv_window_scan_ctrl #(.DW(8), .IMG_SIZE(5), .MEM_ADDR(3)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_in_add_row(mem_in_add_row), .mem_in_add_col(mem_in_add_col),
      .mem_a_add_row(mem_a_add_row), .mem_a_add_col(mem_a_add_col),
      .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       start;
      logic       abort;
      logic       pix_valid;
      logic       exp_busy;
      logic       exp_ready;
      logic       exp_wr;
      logic [2:0] exp_col;
   } vec_t;

   vec_t        tbl [8];
   logic [13:0] wq [$];
   logic [5:0]  winq [$];
   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   int hold22 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      start_cyc = cyc;
      hold22 = 0;
      step();
      start = 1'b0;
   endtask

   task automatic load(input bit drop, input int abort_at);
      for (int k = 0; k < 25; k++) begin
         if (k == abort_at) begin
            pix_valid = 1'b1;
            pix_in = 8'(k + 1);
            abort = 1'b1;
            #1;
            chk("load_abort_ready", pix_ready, 0);
            chk("load_abort_wr", mem_wr_en, 0);
            step();
            abort = 1'b0;
            pix_valid = 1'b0;
            #1;
            chk("load_abort_idle", busy, 0);
            step();
            return;
         end
         if (drop && (k % 2 == 1)) begin
            pix_valid = 1'b0;
            step();
         end
         pix_valid = 1'b1;
         pix_in = 8'(k + 1);
         wq.push_back({3'(k / 5), 3'(k % 5), 8'(k + 1)});
         step();
      end
      pix_valid = 1'b0;
   endtask

   task automatic scan(input bit stall, input int abort_at);
      for (int w = 0; w < 9; w++) begin
         if (w == 0) begin
            #1;
            chk("scan_entry", {win_valid, mem_a_add_row, mem_a_add_col}, {1'b1, 3'd1, 3'd1});
         end
         if (w == abort_at) begin
            win_ready = 1'b1;
            abort = 1'b1;
            #1;
            chk("scan_abort_valid", win_valid, 0);
            chk("scan_abort_rd", mem_rd_en, 0);
            step();
            abort = 1'b0;
            win_ready = 1'b0;
            #1;
            chk("scan_abort_idle", busy, 0);
            step();
            return;
         end
         if (stall && w == 4) begin
            win_ready = 1'b0;
            repeat (3) step();
         end
         win_ready = 1'b1;
         winq.push_back({3'(1 + w / 3), 3'(1 + w % 3)});
         step();
      end
      win_ready = 1'b0;
      #1;
      chk("done_pulse", {done, busy}, 2'b11);
      step();
      #1;
      chk("after_done", {done, busy}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] ew;
      logic [5:0]  ewin;

      tbl[0] = '{1, 1, 0, 0, 0, 0, 0};
      tbl[1] = '{0, 0, 1, 0, 0, 0, 0};
      tbl[2] = '{1, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{1, 0, 1, 1, 1, 1, 0};
      tbl[4] = '{1, 0, 0, 1, 1, 0, 0};
      tbl[5] = '{0, 0, 1, 1, 1, 1, 1};
      tbl[6] = '{1, 1, 1, 1, 0, 0, 0};
      tbl[7] = '{0, 0, 0, 0, 0, 0, 0};

      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               chk("wr_rd_excl", {31'd0, mem_wr_en & mem_rd_en}, 0);
               if (!busy)
                  chk("idle_outs", {pix_ready, mem_wr_en, mem_rd_en, win_valid, done, mem_data_in,
                                    mem_in_add_row, mem_in_add_col, mem_a_add_row, mem_a_add_col}, 0);
               if (mem_wr_en) begin
                  chk("wr_expected", wq.size() != 0, 1);
                  if (wq.size() != 0) begin
                     ew = wq.pop_front();
                     chk("wr_row_col_data", {mem_in_add_row, mem_in_add_col, mem_data_in}, ew);
                  end
               end
               if (win_valid && win_ready) begin
                  chk("win_expected", winq.size() != 0, 1);
                  if (winq.size() != 0) begin
                     ewin = winq.pop_front();
                     chk("win_centre", {mem_a_add_row, mem_a_add_col}, ewin);
                  end
               end
               if (win_valid && mem_a_add_row == 3'd2 && mem_a_add_col == 3'd2) hold22++;
               if (done) begin
                  n_done++;
                  done_cyc = cyc;
               end
            end
         end
      join_none

      #3;
      chk("reset_outs", {busy, pix_ready, mem_wr_en, mem_rd_en, win_valid, done}, 0);
      #4;
      reset = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         start = tbl[i].start;
         abort = tbl[i].abort;
         pix_valid = tbl[i].pix_valid;
         pix_in = 8'(8'hA0 + i);
         if (tbl[i].exp_wr) wq.push_back({3'd0, tbl[i].exp_col, 8'(8'hA0 + i)});
         #1;
         chk($sformatf("vec%0d", i), {busy, pix_ready, mem_wr_en},
             {tbl[i].exp_busy, tbl[i].exp_ready, tbl[i].exp_wr});
         step();
      end
      start = 1'b0;
      abort = 1'b0;
      pix_valid = 1'b0;

      do_start();
      load(0, -1);
      scan(0, -1);
      chk("pass1_done_cnt", n_done, 1);
      chk("pass1_cycles", done_cyc - start_cyc + 1, 36);
      chk("pass1_hold22", hold22, 1);

      do_start();
      load(1, -1);
      scan(1, -1);
      chk("pass2_done_cnt", n_done, 2);
      chk("pass2_hold22", hold22, 4);

      do_start();
      load(0, 9);
      chk("abort_load_no_done", n_done, 2);

      do_start();
      load(0, -1);
      scan(0, 4);
      chk("abort_scan_no_done", n_done, 2);

      do_start();
      load(0, -1);
      win_ready = 1'b1;
      for (int w = 0; w < 2; w++) begin
         winq.push_back({3'd1, 3'(1 + w)});
         step();
      end
      win_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_outs", {busy, win_valid, mem_rd_en, mem_a_add_row, mem_a_add_col}, 0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      step();
      chk("reset_no_done", n_done, 2);

      do_start();
      load(0, -1);
      scan(0, -1);
      chk("pass_after_reset_done", n_done, 3);
      chk("pass_after_reset_cycles", done_cyc - start_cyc + 1, 36);

      chk("wq_drained", wq.size(), 0);
      chk("winq_drained", winq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_window_scan_ctrl.md
# conv_window_scan_ctrl

Sequencer for the 3-row windowed feature memory used in the CNN front end. It loads an IMG_SIZE x IMG_SIZE pixel stream into the memory in raster order, then steps the 3x3 read window across every interior position while the convolution engine applies backpressure. It drives the memory's write and read enables and both address pairs, and signals completion to the layer controller.

## Interface
- DW, 8, pixel width.
- IMG_SIZE, 5, image edge length; must be at least 3 and match the memory size.
- MEM_ADDR, 3, address width; 2^MEM_ADDR >= IMG_SIZE.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load+scan pass; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- pix_in  in  DW  incoming pixel.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  controller accepts a pixel this cycle.
- mem_data_in  out  DW  memory write data.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory window read enable.
- mem_in_add_row / mem_in_add_col  out  MEM_ADDR each  write address.
- mem_a_add_row / mem_a_add_col  out  MEM_ADDR each  window-centre address.
- win_valid  out  1  memory window outputs are valid this cycle.
- win_ready  in  1  convolution engine consumes the window.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at the end of the pass.

## Operation
- States: IDLE, LOAD, SCAN, DONE. The state is registered. All outputs are decoded combinationally from the state, the counters and the current inputs.
- IDLE:
  - All outputs are 0.
  - start=1 and abort=0 -> LOAD. The write counters clear to (0,0).
- LOAD:
  - pix_ready=1.
  - mem_wr_en = pix_valid. mem_data_in = pix_in.
  - mem_in_add_row/col = write counters.
  - On each accept (pix_valid & pix_ready), col increments. At col=IMG_SIZE-1, col wraps to 0 and row increments.
  - Accept at (IMG_SIZE-1, IMG_SIZE-1) -> SCAN. The scan counters load (1,1).
  - pix_valid=0 stalls the controller with the counters held.
- SCAN:
  - mem_rd_en=1 and win_valid=1.
  - mem_a_add_row/col = scan counters. Both ranges are 1..IMG_SIZE-2.
  - On win_ready, col increments. At col=IMG_SIZE-2, col wraps to 1 and row increments.
  - Accept at (IMG_SIZE-2, IMG_SIZE-2) -> DONE.
  - The window count per pass is (IMG_SIZE-2)^2.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- mem_wr_en and mem_rd_en are never high in the same cycle.
- Address outputs not used in the current state are 0.
- abort=1 in any state -> IDLE on the next edge.
  - No done pulse is produced. Memory contents are not cleared.
  - In the abort cycle, pix_ready, mem_wr_en, mem_rd_en and win_valid are forced to 0.
  - abort has priority over start and over every transition.
- start outside IDLE is ignored.
- Counters are MEM_ADDR bits wide and never exceed IMG_SIZE-1.

## Timing
- Asynchronous reset assertion: state -> IDLE, all counters -> 0, all outputs 0. The first start is sampled on the first rising edge after reset deasserts.
- Reset mid-pass: same as above. Any partially loaded memory content is stale and is reloaded by the next pass.
- Cycle numbering:
  - start sampled at edge 0.
  - pix_ready is high from cycle 1.
  - The last pixel is written at its accept edge.
  - win_valid is high in the very next cycle.
- The memory read path is combinational, so the window data is valid in the same cycle as win_valid. The engine must capture it on the edge where win_ready=1.
- Minimum pass with pix_valid and win_ready held high: 1 + IMG_SIZE^2 + (IMG_SIZE-2)^2 + 1 cycles from the start edge to the end of the done cycle. With the default size, that is 36 cycles.
- Throughput is one pixel per cycle in LOAD and one window per cycle in SCAN.

## Test plan
- Reset, then start; stream pixels 1..25 with pix_valid held high -> 25 writes at (0,0)..(4,4) with data = index, mem_wr_en high for 25 cycles, SCAN entered on the next cycle.
- SCAN with win_ready held high -> 9 windows at centres (1,1),(1,2),(1,3),(2,1)..(3,3), mem_rd_en never overlaps mem_wr_en, done pulses once, busy falls in the following cycle.
- Drop pix_valid every other cycle and hold win_ready low for 3 cycles at centre (2,2) -> counters hold, no duplicate or skipped addresses, the (2,2) window is held valid for 4 cycles.
- Assert abort during LOAD at pixel 10 and again during SCAN at window 5 -> IDLE on the next edge, no done pulse; a new start begins from (0,0).
- Assert start while busy, and start together with abort in IDLE -> both are ignored; the controller stays in its current state or in IDLE.
- Assert reset asynchronously mid-SCAN between clock edges -> all outputs are 0 immediately; a subsequent pass completes normally in 36 cycles.
